// File: rtl/prach_occ_ctrl_if.sv
`default_nettype none
// ============================================================================
// prach_occ_ctrl_if
// Beat stream, window configuration and status bundle for prach_occ_ctrl.
// Revision: 1.0
// ============================================================================
interface prach_occ_ctrl_if #(
  parameter int N_CC  = 3,
  parameter int N_ANT = 8,
  parameter int CNT_W = 20
) ();
  logic                             din_dv;
  logic [7:0]                       din_chn;
  logic                             sync_in;
  logic [N_CC-1:0]                  cfg_en;
  logic [N_CC-1:0][CNT_W-1:0]       cfg_start;
  logic [N_CC-1:0][CNT_W-1:0]       cfg_len;
  logic [N_CC-1:0][N_ANT-1:0]       cfg_ant_mask;
  logic                             err_clr;
  logic                             dout_dv;
  logic [7:0]                       dout_chn;
  logic [N_CC-1:0]                  win_gate;
  logic [N_CC-1:0]                  win_sop;
  logic [N_CC-1:0]                  win_eop;
  logic [N_CC-1:0][15:0]            occ_cnt;
  logic                             err_sync;
  logic [N_CC-1:0]                  err_abort;

  modport master (
    output din_dv, din_chn, sync_in, cfg_en, cfg_start, cfg_len, cfg_ant_mask, err_clr,
    input  dout_dv, dout_chn, win_gate, win_sop, win_eop, occ_cnt, err_sync, err_abort
  );
  modport slave (
    input  din_dv, din_chn, sync_in, cfg_en, cfg_start, cfg_len, cfg_ant_mask, err_clr,
    output dout_dv, dout_chn, win_gate, win_sop, win_eop, occ_cnt, err_sync, err_abort
  );
endinterface
`default_nettype wire

// File: rtl/prach_occ_ctrl.sv
`default_nettype none
// ============================================================================
// prach_occ_ctrl
// Tracks the frame sample index and opens per-CC PRACH occasion windows.
// Revision: 1.0
// ============================================================================
module prach_occ_ctrl #(
  parameter int N_CC  = 3,
  parameter int N_ANT = 8,
  parameter int CNT_W = 20
) (
  input  wire logic           clk_dsp,
  input  wire logic           rst_dsp_n,
  prach_occ_ctrl_if.slave     bus
);
  localparam int AW = (N_ANT > 1) ? $clog2(N_ANT) : 1;
  localparam logic [AW-1:0] LAST_ANT = AW'(N_ANT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACTIVE, ST_DONE} state_t;

  state_t                     state_q [N_CC];
  state_t                     state_d [N_CC];
  logic [CNT_W-1:0]           rem_q [N_CC];
  logic [CNT_W-1:0]           rem_d [N_CC];
  logic [N_CC-1:0]            first_q, first_d;
  logic [N_CC-1:0]            en_q, en_d;
  logic [N_CC-1:0][CNT_W-1:0] start_q, start_d, len_q, len_d;
  logic [N_CC-1:0][N_ANT-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]           idx_q, idx_d;
  logic [N_CC-1:0]            gate_q, gate_d, sop_q, sop_d, eop_q, eop_d;
  logic [N_CC-1:0][15:0]      occ_q, occ_d;
  logic                       err_sync_q, err_sync_d;
  logic [N_CC-1:0]            err_abort_q, err_abort_d;
  logic                       dv_q;
  logic [7:0]                 chn_q;

  logic [AW-1:0]    w_chn;
  logic             w_per, w_vsync, w_bad_sync;
  logic [CNT_W-1:0] w_s;

  assign w_chn      = bus.din_chn[AW-1:0];
  assign w_per      = bus.din_dv && (w_chn == LAST_ANT);
  assign w_vsync    = bus.din_dv && bus.sync_in && (w_chn == '0);
  assign w_bad_sync = bus.din_dv && bus.sync_in && (w_chn != '0);
  assign w_s        = w_vsync ? '0 : idx_q;

  always_comb begin
    idx_d       = idx_q;
    en_d        = en_q;
    start_d     = start_q;
    len_d       = len_q;
    mask_d      = mask_q;
    first_d     = first_q;
    occ_d       = occ_q;
    gate_d      = '0;
    sop_d       = '0;
    eop_d       = '0;
    err_sync_d  = w_bad_sync | (err_sync_q & ~bus.err_clr);
    err_abort_d = err_abort_q & ~{N_CC{bus.err_clr}};
    for (int i = 0; i < N_CC; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
    end

    if (w_per)
      idx_d = (w_s == {CNT_W{1'b1}}) ? w_s : w_s + CNT_W'(1);
    else if (w_vsync)
      idx_d = '0;

    if (w_vsync) begin
      en_d    = bus.cfg_en;
      start_d = bus.cfg_start;
      len_d   = bus.cfg_len;
      mask_d  = bus.cfg_ant_mask;
    end

    for (int i = 0; i < N_CC; i++) begin
      logic             inwin;
      logic [CNT_W-1:0] rem_cur;
      logic             first_cur;
      logic [N_ANT-1:0] mask_sel;
      inwin     = 1'b0;
      rem_cur   = rem_q[i];
      first_cur = first_q[i];
      mask_sel  = w_vsync ? bus.cfg_ant_mask[i] : mask_q[i];

      // A valid sync restarts every CC from the freshly captured config
      if (w_vsync) begin
        if (state_q[i] == ST_ACTIVE)
          err_abort_d[i] = 1'b1;
        if (!bus.cfg_en[i] || bus.cfg_len[i] == '0) begin
          state_d[i] = ST_IDLE;
        end else if (bus.cfg_start[i] == '0) begin
          state_d[i] = ST_ACTIVE;
          inwin      = 1'b1;
          rem_cur    = bus.cfg_len[i];
          first_cur  = 1'b1;
        end else begin
          state_d[i] = ST_WAIT;
        end
      end else if (bus.din_dv) begin
        case (state_q[i])
          ST_WAIT: begin
            if (w_chn == '0 && w_s == start_q[i]) begin
              state_d[i] = ST_ACTIVE;
              inwin      = 1'b1;
              rem_cur    = len_q[i];
              first_cur  = 1'b1;
            end
          end
          ST_ACTIVE: inwin = 1'b1;
          default: ;
        endcase
      end

      if (inwin) begin
        gate_d[i] = mask_sel[w_chn];
        sop_d[i]  = (w_chn == '0) && first_cur;
        eop_d[i]  = w_per && (rem_cur == CNT_W'(1));
        if (w_per) begin
          first_d[i] = 1'b0;
          if (rem_cur == CNT_W'(1)) begin
            occ_d[i]   = occ_q[i] + 16'd1;
            state_d[i] = ST_DONE;
          end
          rem_d[i] = rem_cur - CNT_W'(1);
        end else begin
          first_d[i] = first_cur;
          rem_d[i]   = rem_cur;
        end
      end
    end
  end

  always_ff @(posedge clk_dsp) begin
    if (!rst_dsp_n) begin
      idx_q       <= '0;
      en_q        <= '0;
      start_q     <= '0;
      len_q       <= '0;
      mask_q      <= '0;
      first_q     <= '0;
      occ_q       <= '0;
      gate_q      <= '0;
      sop_q       <= '0;
      eop_q       <= '0;
      err_sync_q  <= 1'b0;
      err_abort_q <= '0;
      dv_q        <= 1'b0;
      chn_q       <= '0;
      for (int i = 0; i < N_CC; i++) begin
        state_q[i] <= ST_IDLE;
        rem_q[i]   <= '0;
      end
    end else begin
      idx_q       <= idx_d;
      en_q        <= en_d;
      start_q     <= start_d;
      len_q       <= len_d;
      mask_q      <= mask_d;
      first_q     <= first_d;
      occ_q       <= occ_d;
      gate_q      <= gate_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      err_sync_q  <= err_sync_d;
      err_abort_q <= err_abort_d;
      dv_q        <= bus.din_dv;
      chn_q       <= bus.din_chn;
      for (int i = 0; i < N_CC; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  assign bus.dout_dv   = dv_q;
  assign bus.dout_chn  = chn_q;
  assign bus.win_gate  = gate_q;
  assign bus.win_sop   = sop_q;
  assign bus.win_eop   = eop_q;
  assign bus.occ_cnt   = occ_q;
  assign bus.err_sync  = err_sync_q;
  assign bus.err_abort = err_abort_q;
endmodule
`default_nettype wire

// File: tb/tb_prach_occ_ctrl.sv
`default_nettype none
// ============================================================================
// tb_prach_occ_ctrl
// Directed frames against hand-derived window timing for prach_occ_ctrl.
// Revision: 1.0
// ============================================================================
module tb_prach_occ_ctrl;
  logic clk_dsp = 1'b0;
  logic rst_dsp_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   occ_exp [3] = '{0, 0, 0};

  prach_occ_ctrl_if #(.N_CC(3), .N_ANT(8), .CNT_W(20)) bus ();
  prach_occ_ctrl #(.N_CC(3), .N_ANT(8), .CNT_W(20)) dut (
    .clk_dsp   (clk_dsp),
    .rst_dsp_n (rst_dsp_n),
    .bus       (bus)
  );

  always #5 clk_dsp = ~clk_dsp;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic dv, input logic [7:0] chn, input logic sync);
    bus.din_dv  = dv;
    bus.din_chn = chn;
    bus.sync_in = sync;
    @(posedge clk_dsp);
    #1;
  endtask

  task automatic set_cc(input int i, input logic en, input int st, input int ln, input logic [7:0] mk);
    bus.cfg_en[i]       = en;
    bus.cfg_start[i]    = 20'(st);
    bus.cfg_len[i]      = 20'(ln);
    bus.cfg_ant_mask[i] = mk;
  endtask

  // One frame: sync on the first beat, nsamp sample periods of 8 beats each
  task automatic run_frame(input int nsamp, input bit gaps, input int bad_s, input int new_len0,
                           input logic [2:0] exp_abort, input logic exp_es);
    int         st [3];
    int         ln [3];
    logic [7:0] mk [3];
    logic       en [3];
    for (int i = 0; i < 3; i++) begin
      st[i] = int'(bus.cfg_start[i]);
      ln[i] = int'(bus.cfg_len[i]);
      mk[i] = bus.cfg_ant_mask[i];
      en[i] = bus.cfg_en[i];
    end
    for (int s = 0; s < nsamp; s++) begin
      for (int c = 0; c < 8; c++) begin
        if (gaps) begin
          for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 1) == 1) begin
              send(1'b0, 8'(c), 1'b0);
              check("idle_out", {28'd0, bus.dout_dv, |bus.win_gate, |bus.win_sop, |bus.win_eop}, 32'd0);
            end
          end
        end
        send(1'b1, 8'(c), (s == 0 && c == 0) || (s == bad_s && c == 3));
        if (s == 0 && c == 0) begin
          check("abort_at_sync", {29'd0, bus.err_abort}, {29'd0, exp_abort});
          if (new_len0 >= 0) bus.cfg_len[0] = 20'(new_len0);
        end
        if (s == 1) check($sformatf("dout_chn c%0d", c), {24'd0, bus.dout_chn}, 32'(c));
        for (int i = 0; i < 3; i++) begin
          logic inw;
          inw = en[i] && ln[i] != 0 && s >= st[i] && s < st[i] + ln[i];
          check($sformatf("win cc%0d s%0d c%0d", i, s, c),
                {29'd0, bus.win_gate[i], bus.win_sop[i], bus.win_eop[i]},
                {29'd0, inw && mk[i][c], inw && c == 0 && s == st[i], inw && c == 7 && s == st[i] + ln[i] - 1});
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (en[i] && ln[i] != 0 && st[i] + ln[i] <= nsamp) occ_exp[i]++;
      check($sformatf("occ_cnt cc%0d", i), {16'd0, bus.occ_cnt[i]}, 32'(occ_exp[i]));
    end
    check("err_sync_end", {31'd0, bus.err_sync}, {31'd0, exp_es});
  endtask

  initial begin
    bus.din_dv = 1'b0; bus.din_chn = '0; bus.sync_in = 1'b0; bus.err_clr = 1'b0;
    bus.cfg_en = '0; bus.cfg_start = '0; bus.cfg_len = '0; bus.cfg_ant_mask = '0;
    repeat (3) @(posedge clk_dsp);
    #1;
    check("rst_dv", {31'd0, bus.dout_dv}, 32'd0);
    check("rst_win", {29'd0, |bus.win_gate, |bus.win_sop, |bus.win_eop}, 32'd0);
    check("rst_occ", {16'd0, bus.occ_cnt[0] | bus.occ_cnt[1] | bus.occ_cnt[2]}, 32'd0);
    check("rst_err", {28'd0, bus.err_sync, bus.err_abort}, 32'd0);
    rst_dsp_n = 1'b1;

    // Mid-frame window with mask 0x81, plus a one-sample window on the sync beat
    set_cc(0, 1'b1, 5, 3, 8'h81);
    set_cc(1, 1'b0, 0, 0, 8'h00);
    set_cc(2, 1'b1, 0, 1, 8'hFF);
    run_frame(10, 1'b0, -1, -1, 3'b000, 1'b0);

    // CC1 window still open when the next sync arrives
    set_cc(0, 1'b0, 5, 3, 8'h81);
    set_cc(1, 1'b1, 4, 10, 8'h0F);
    run_frame(6, 1'b0, -1, -1, 3'b000, 1'b0);
    set_cc(1, 1'b1, 2, 2, 8'hF0);
    run_frame(5, 1'b0, 3, -1, 3'b010, 1'b1);

    bus.err_clr = 1'b1;
    send(1'b0, 8'd0, 1'b0);
    check("err_clr_sync", {31'd0, bus.err_sync}, 32'd0);
    check("err_clr_abort", {29'd0, bus.err_abort}, 32'd0);
    send(1'b1, 8'd3, 1'b1);
    check("err_set_wins", {31'd0, bus.err_sync}, 32'd1);
    send(1'b0, 8'd0, 1'b0);
    check("err_clr_again", {31'd0, bus.err_sync}, 32'd0);
    bus.err_clr = 1'b0;

    // Same first config with random dv gaps, then a mid-frame length change
    set_cc(0, 1'b1, 5, 3, 8'h81);
    set_cc(1, 1'b0, 0, 0, 8'h00);
    set_cc(2, 1'b0, 0, 0, 8'h00);
    run_frame(10, 1'b1, -1, -1, 3'b000, 1'b0);
    run_frame(10, 1'b0, -1, 7, 3'b000, 1'b0);
    run_frame(13, 1'b0, -1, -1, 3'b000, 1'b0);

    // Reset while CC0 is active
    set_cc(0, 1'b1, 0, 7, 8'hFF);
    send(1'b1, 8'd0, 1'b1);
    send(1'b1, 8'd1, 1'b0);
    check("pre_rst_gate", {31'd0, bus.win_gate[0]}, 32'd1);
    rst_dsp_n = 1'b0;
    send(1'b1, 8'd2, 1'b0);
    check("rst_act_dv", {23'd0, bus.dout_dv, bus.dout_chn}, 32'd0);
    check("rst_act_win", {23'd0, bus.win_gate, bus.win_sop, bus.win_eop}, 32'd0);
    check("rst_act_occ", {16'd0, bus.occ_cnt[0]}, 32'd0);
    check("rst_act_err", {28'd0, bus.err_sync, bus.err_abort}, 32'd0);
    rst_dsp_n = 1'b1;
    send(1'b0, 8'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
